// File: rtl/quad_pkg.sv
// Shared constants, FSM encoding and phase-stepping helper for the quadrature generator.
package quad_pkg;

    // Quadrature phase, packed as {a, b}
    typedef logic [1:0] phase_t;

    localparam phase_t PH_00 = 2'b00;
    localparam phase_t PH_10 = 2'b10;
    localparam phase_t PH_11 = 2'b11;
    localparam phase_t PH_01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Wide enough for the largest legal EDGE_DIV (65535)
    localparam int unsigned TMR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDGE1,
        S_EDGE2,
        S_FINISH
    } state_t;

    // Up walks 00->10->11->01->00; down walks the same ring backwards.
    function automatic phase_t next_phase(input phase_t ph, input logic dir);
        phase_t up_ph;
        phase_t dn_ph;
        case (ph)
            PH_00:   begin up_ph = PH_10; dn_ph = PH_01; end
            PH_10:   begin up_ph = PH_11; dn_ph = PH_00; end
            PH_11:   begin up_ph = PH_01; dn_ph = PH_10; end
            default: begin up_ph = PH_00; dn_ph = PH_11; end
        endcase
        return (dir == DIR_DOWN) ? dn_ph : up_ph;
    endfunction

endpackage

// File: rtl/quad_edge_timer.sv
// Loadable down-counter; o_tick_c marks the clock on which the count reaches zero,
// and the counter reloads EDGE_DIV on that same clock.
module quad_edge_timer
    import quad_pkg::*;
#(
    parameter int unsigned EDGE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_tick_c
);

    localparam logic [TMR_W-1:0] DIV_V = TMR_W'(EDGE_DIV);

    logic [TMR_W-1:0] r_count;

    assign o_tick_c = i_en && (r_count == TMR_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load || o_tick_c) begin
            r_count <= DIV_V;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

endmodule

// File: rtl/quad_gen.sv
// Quadrature A/B step generator with a mirror position counter.
// Optional index channel z is built when QUAD_GEN_INDEX_EN is defined.
module quad_gen
    import quad_pkg::*;
#(
    parameter int unsigned EDGE_DIV = 4,
    parameter int unsigned COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [COUNT_W-1:0] cmd_steps,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] position
`ifdef QUAD_GEN_INDEX_EN
    ,
    output logic               z
`endif
);

    state_t               r_state;
    state_t               w_state_nxt;
    phase_t               r_ab;
    phase_t               w_ab_nxt;
    logic [COUNT_W-1:0]   r_pos;
    logic [COUNT_W-1:0]   w_pos_nxt;
    logic [COUNT_W-1:0]   r_rem;
    logic [COUNT_W-1:0]   w_rem_nxt;
    logic                 r_dir;
    logic                 w_dir_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_ready;
    logic                 w_ready_nxt;
    logic                 w_load;
    logic                 w_en;
    logic                 w_tick;

    quad_edge_timer #(
        .EDGE_DIV (EDGE_DIV)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_en     (w_en),
        .o_tick_c (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ab    <= PH_00;
            r_pos   <= '0;
            r_rem   <= '0;
            r_dir   <= DIR_UP;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ab    <= w_ab_nxt;
            r_pos   <= w_pos_nxt;
            r_rem   <= w_rem_nxt;
            r_dir   <= w_dir_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next-state and next-register values; outputs are registered from these
    always_comb begin
        w_state_nxt = r_state;
        w_ab_nxt    = r_ab;
        w_pos_nxt   = r_pos;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_en        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_dir_nxt = cmd_dir;
                    if (cmd_steps == '0) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_rem_nxt   = cmd_steps;
                        w_load      = 1'b1;
                        w_state_nxt = S_EDGE1;
                    end
                end
            end
            S_EDGE1: begin
                w_en = 1'b1;
                if (w_tick) begin
                    w_ab_nxt    = next_phase(r_ab, r_dir);
                    w_pos_nxt   = (r_dir == DIR_UP) ? r_pos + COUNT_W'(1)
                                                    : r_pos - COUNT_W'(1);
                    w_state_nxt = S_EDGE2;
                end
            end
            S_EDGE2: begin
                w_en = 1'b1;
                if (w_tick) begin
                    w_ab_nxt    = next_phase(r_ab, r_dir);
                    w_rem_nxt   = r_rem - COUNT_W'(1);
                    w_state_nxt = (r_rem == COUNT_W'(1)) ? S_FINISH : S_EDGE1;
                end
            end
            S_FINISH: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt  = (w_state_nxt == S_EDGE1) || (w_state_nxt == S_EDGE2);
        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

    assign a         = r_ab[1];
    assign b         = r_ab[0];
    assign position  = r_pos;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cmd_ready = r_ready;

`ifdef QUAD_GEN_INDEX_EN
    logic             r_z;
    logic [TMR_W-1:0] r_z_cnt;
    logic             w_zero_hit;

    // Index pulse: EDGE_DIV clocks wide, launched by the counting edge landing on zero
    assign w_zero_hit = (r_state == S_EDGE1) && w_tick && (w_pos_nxt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_z     <= 1'b0;
            r_z_cnt <= '0;
        end else if (w_zero_hit) begin
            r_z     <= 1'b1;
            r_z_cnt <= TMR_W'(EDGE_DIV - 1);
        end else if (r_z_cnt != '0) begin
            r_z_cnt <= r_z_cnt - TMR_W'(1);
        end else begin
            r_z     <= 1'b0;
        end
    end

    assign z = r_z;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// Directed bench for quad_gen (EDGE_DIV=4, COUNT_W=8) with an x4 quadrature decoder model.
// Index-channel checks are included when QUAD_GEN_INDEX_EN is defined.
module tb_quad_gen;

    localparam int unsigned EDGE_DIV = 4;
    localparam int unsigned COUNT_W  = 8;

    logic               clk       = 1'b0;
    logic               reset     = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_dir   = 1'b0;
    logic [COUNT_W-1:0] cmd_steps = '0;
    logic               cmd_ready;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] position;
    logic [1:0]         ab;
`ifdef QUAD_GEN_INDEX_EN
    logic               z;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int illegal     = 0;

    quad_gen #(
        .EDGE_DIV (EDGE_DIV),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .position  (position)
`ifdef QUAD_GEN_INDEX_EN
        ,
        .z         (z)
`endif
    );

    assign ab = {a, b};

    always #5 clk = ~clk;

    // Reference x4 decoder: +-1 per legal transition, reported value is count/2
    function automatic logic [1:0] gidx(input logic [1:0] ph);
        case (ph)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [1:0] dec_prev;
    logic [8:0] dec_cnt;
    logic [7:0] dec_val;
    assign dec_val = dec_cnt[8:1];

    always @(posedge clk) begin
        if (reset) begin
            dec_prev <= 2'b00;
            dec_cnt  <= '0;
        end else begin
            dec_prev <= ab;
            case (2'(gidx(ab) - gidx(dec_prev)))
                2'd1:    dec_cnt <= dec_cnt + 9'd1;
                2'd3:    dec_cnt <= dec_cnt - 9'd1;
                2'd2:    illegal <= illegal + 1;
                default: ;
            endcase
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one command; returns just after the transfer edge
    task automatic send(input logic d, input logic [7:0] s);
        chk1("ready_before_send", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_steps = s;
        cyc(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [1:0] exp_up3 [6];
    logic [1:0] prev;
    int         done_seen;

    initial begin
        exp_up3 = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};

        // Reset state
        cyc(2);
        chk2("rst_ab", ab, 2'b00);
        chk8("rst_pos", position, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ready", cmd_ready, 1'b1);
`ifdef QUAD_GEN_INDEX_EN
        chk1("rst_z", z, 1'b0);
`endif
        reset = 1'b0;
        cyc(1);

        // up/3: six edges every 4 clocks, done at t+25
        send(1'b1, 8'd3);
        chk1("up3_busy_t0", busy, 1'b1);
        chk1("up3_ready_t0", cmd_ready, 1'b0);
        prev = 2'b00;
        for (int k = 0; k < 6; k++) begin
            cyc(3);
            chk2($sformatf("up3_hold%0d", k), ab, prev);
            cyc(1);
            chk2($sformatf("up3_edge%0d", k), ab, exp_up3[k]);
            prev = exp_up3[k];
        end
        chk1("up3_done_t24", done, 1'b0);
        chk8("up3_pos_t24", position, 8'd3);
        cyc(1);
        chk1("up3_done_t25", done, 1'b1);
        chk1("up3_busy_t25", busy, 1'b0);
        chk8("up3_pos_t25", position, 8'd3);
        chk8("up3_dec", dec_val, 8'd3);
        cyc(1);
        chk1("up3_done_t26", done, 1'b0);
        chk1("up3_ready_t26", cmd_ready, 1'b1);

        // down/1 from reset: 00->01->11, position wraps to 255
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk2("rst2_ab", ab, 2'b00);
        chk8("rst2_pos", position, 8'h00);
        send(1'b0, 8'd1);
        cyc(3);
        chk2("dn1_hold", ab, 2'b00);
        cyc(1);
        chk2("dn1_edge1", ab, 2'b01);
        chk8("dn1_pos_t4", position, 8'hff);
        cyc(4);
        chk2("dn1_edge2", ab, 2'b11);
        cyc(1);
        chk1("dn1_done", done, 1'b1);
        chk8("dn1_pos", position, 8'hff);
        chk8("dn1_dec", dec_val, 8'hff);
        cyc(1);

        // zero-step command: no edges, busy never set, done at t+1
        send(1'b1, 8'd0);
        chk1("z0_busy_t0", busy, 1'b0);
        chk1("z0_ready_t0", cmd_ready, 1'b0);
        cyc(1);
        chk1("z0_done", done, 1'b1);
        chk1("z0_busy_t1", busy, 1'b0);
        chk2("z0_ab", ab, 2'b11);
        chk8("z0_pos", position, 8'hff);
        cyc(1);
        chk1("z0_done_t2", done, 1'b0);
        chk1("z0_ready_t2", cmd_ready, 1'b1);

        // up/255 then up/2 offered continuously: second waits for done
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        send(1'b1, 8'd255);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd2;
        cyc(2039);
        chk1("long_busy", busy, 1'b1);
        chk1("long_ready", cmd_ready, 1'b0);
        chk2("long_ab_t2039", ab, 2'b10);
        chk8("long_pos_t2039", position, 8'hff);
        cyc(1);
        chk2("long_ab_t2040", ab, 2'b11);
        chk1("long_done_t2040", done, 1'b0);
        cyc(1);
        chk1("long_done", done, 1'b1);
        chk8("long_pos", position, 8'hff);
        chk8("long_dec", dec_val, 8'hff);
        cyc(1);
        chk1("held_accept_busy", busy, 1'b1);
        chk1("held_accept_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        cyc(3);
        chk2("held_hold", ab, 2'b11);
`ifdef QUAD_GEN_INDEX_EN
        chk1("z_before", z, 1'b0);
`endif
        cyc(1);
        chk2("held_edge1", ab, 2'b01);
        chk8("wrap_pos0", position, 8'h00);
`ifdef QUAD_GEN_INDEX_EN
        chk1("z_start", z, 1'b1);
        cyc(3);
        chk1("z_last", z, 1'b1);
        cyc(1);
        chk1("z_end", z, 1'b0);
`else
        cyc(4);
`endif
        chk2("held_edge2", ab, 2'b00);
        cyc(4);
        chk2("held_edge3", ab, 2'b10);
        chk8("wrap_pos1", position, 8'h01);
        cyc(4);
        chk2("held_edge4", ab, 2'b11);
        cyc(1);
        chk1("held_done", done, 1'b1);
        chk8("held_pos", position, 8'h01);
        chk8("held_dec", dec_val, 8'h01);
        cyc(1);

        // reset after the third edge of up/5
        send(1'b1, 8'd5);
        cyc(4);
        chk2("r5_edge1", ab, 2'b01);
        cyc(4);
        chk2("r5_edge2", ab, 2'b00);
        cyc(4);
        chk2("r5_edge3", ab, 2'b10);
        chk8("r5_pos_t12", position, 8'd3);
        reset = 1'b1;
        cyc(1);
        chk2("r5_ab", ab, 2'b00);
        chk8("r5_pos", position, 8'h00);
        chk1("r5_busy", busy, 1'b0);
        chk1("r5_ready", cmd_ready, 1'b1);
        chk1("r5_done", done, 1'b0);
        reset     = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (done) done_seen++;
        end
        chk8("r5_no_done", 8'(done_seen), 8'd0);
        chk2("r5_ab_after", ab, 2'b00);
        chk1("r5_busy_after", busy, 1'b0);

        // reach rest 11, then up/1 and down/1: 11->01->00->01->11
        send(1'b1, 8'd1);
        cyc(8);
        chk2("pre_rest11", ab, 2'b11);
        cyc(1);
        chk8("pre_dec", dec_val, 8'h01);
        cyc(1);
        send(1'b1, 8'd1);
        cyc(4);
        chk2("rt_up_e1", ab, 2'b01);
        cyc(4);
        chk2("rt_up_e2", ab, 2'b00);
        cyc(1);
        chk8("rt_up_pos", position, 8'h02);
        chk8("rt_up_dec", dec_val, 8'h02);
        cyc(1);
        send(1'b0, 8'd1);
        cyc(4);
        chk2("rt_dn_e1", ab, 2'b01);
        cyc(4);
        chk2("rt_dn_e2", ab, 2'b11);
        cyc(1);
        chk1("rt_dn_done", done, 1'b1);
        chk8("rt_dn_pos", position, 8'h01);
        chk8("rt_dn_dec", dec_val, 8'h01);
        chk8("illegal_transitions", 8'(illegal), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
